// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus sweep and golden-function checker for N-input reduction gates
module gate_sweep_checker #(
  parameter int N    = 4,
  parameter int HOLD = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_y,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec
);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic [1:0] mode_q;
  logic exp_y, last;
  always_comb begin
    exp_y = mode_q == 2'd0 ? ~&stim : mode_q == 2'd1 ? ~|stim : mode_q == 2'd2 ? ^stim : ~^stim;
    last = hold_cnt == HW'(HOLD - 1);
  end
  assign pass = done && err_count == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stim <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec <= '0;
      hold_cnt <= '0;
      mode_q <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= SWEEP;
          busy <= 1'b1;
          done <= 1'b0;
          stim <= '0;
          hold_cnt <= '0;
          err_count <= '0;
          first_fail_valid <= 1'b0;
          first_fail_vec <= '0;
          mode_q <= mode;
        end
        SWEEP: if (!last) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else begin
          if (dut_y != exp_y) begin
            err_count <= err_count + (N+1)'(1);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec <= stim;
            end
          end
          hold_cnt <= '0;
          if (&stim) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            stim <= '0;
          end else begin
            stim <= stim + N'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: directed sweeps against a cycle-level model of the checker plus literal expectations
module tb_gate_sweep_checker;
  localparam int H = 2;
  localparam int V = 16;
  logic clk = 0, rst_n = 0, start_a = 0, start_b = 0;
  logic [1:0] mode_a = 0, mode_b = 3;
  logic [3:0] stim_a, ffvec_a;
  logic [4:0] err_a;
  logic busy_a, done_a, pass_a, ffv_a, dut_y_a;
  logic [0:0] stim_b, ffvec_b;
  logic [1:0] err_b;
  logic busy_b, done_b, pass_b, ffv_b, dut_y_b;
  int fault_kind = 0;
  int checks = 0, failures = 0, lat;
  bit m_active = 0, m_done = 0, m_ffv = 0;
  int m_t = 0, m_errs = 0, m_ffvec = 0, m_mode = 0;

  gate_sweep_checker #(.N(4), .HOLD(H)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .dut_y(dut_y_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));
  gate_sweep_checker #(.N(1), .HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .dut_y(dut_y_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

  always #5 clk = ~clk;

  // 4-input NAND under test; kind 1 plants a stuck-high output at vector 15
  function automatic logic gate_fn(int v, int kind);
    return (kind == 1 && v == 15) ? 1'b1 : (v != 15);
  endfunction
  function automatic logic golden(int v, int md);
    int p = $countones(v);
    return md == 0 ? (p != 4) : md == 1 ? (p == 0) : md == 2 ? (p % 2 == 1) : (p % 2 == 0);
  endfunction

  assign dut_y_a = gate_fn(int'(stim_a), fault_kind);
  assign dut_y_b = ~stim_b[0];

  // m_t counts edges since the accepted start; vector m_t/H is sampled when m_t%H == H-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_done <= 0; m_t <= 0; m_errs <= 0; m_ffv <= 0; m_ffvec <= 0; m_mode <= 0;
    end else if (!m_active) begin
      if (start_a) begin
        m_active <= 1; m_done <= 0; m_t <= 0; m_errs <= 0; m_ffv <= 0; m_ffvec <= 0; m_mode <= int'(mode_a);
      end
    end else begin
      if (m_t % H == H - 1 && gate_fn(m_t / H, fault_kind) != golden(m_t / H, m_mode)) begin
        m_errs <= m_errs + 1;
        if (!m_ffv) begin
          m_ffv <= 1;
          m_ffvec <= m_t / H;
        end
      end
      m_t <= m_t + 1;
      if (m_t == V * H - 1) begin
        m_active <= 0;
        m_done <= 1;
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (rst_n) begin
      chk("stim", int'(stim_a), m_active ? m_t / H : 0);
      chk("busy", int'(busy_a), int'(m_active));
      chk("done", int'(done_a), int'(m_done));
      chk("pass", int'(pass_a), int'(m_done && m_errs == 0));
      chk("err_count", int'(err_a), m_errs);
      chk("ffv", int'(ffv_a), int'(m_ffv));
      chk("ffvec", int'(ffvec_a), m_ffvec);
    end
  endtask

  task automatic run_a(input int md, input int kind, input bit poke, output int n);
    fault_kind = kind;
    mode_a = 2'(md);
    start_a = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      n++;
      if (i == 0) start_a = 0;
      if (poke && i == 10) start_a = 1;
      if (poke && i == 11) start_a = 0;
      if (done_a) break;
    end
    n--;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_stim"}, int'(stim_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_err"}, int'(err_a), 0);
    chk({tag, "_ffv"}, int'(ffv_a), 0);
    chk({tag, "_ffvec"}, int'(ffvec_a), 0);
  endtask

  initial begin
    #12 chk_zero("reset");
    chk("reset_b_stim", int'(stim_b), 0);
    @(negedge clk);
    rst_n = 1;
    cycle();
    cycle();
    run_a(0, 0, 0, lat);
    chk("nand_lat", lat, 32);
    chk("nand_err", int'(err_a), 0);
    chk("nand_pass", int'(pass_a), 1);
    chk("nand_ffv", int'(ffv_a), 0);
    chk("nand_stim", int'(stim_a), 0);
    run_a(0, 1, 0, lat);
    chk("fault_err", int'(err_a), 1);
    chk("fault_ffvec", int'(ffvec_a), 15);
    chk("fault_ffv", int'(ffv_a), 1);
    chk("fault_pass", int'(pass_a), 0);
    run_a(2, 0, 1, lat);
    chk("xor_lat", lat, 32);
    chk("xor_err", int'(err_a), 7);
    chk("xor_ffvec", int'(ffvec_a), 0);
    chk("xor_pass", int'(pass_a), 0);
    run_a(0, 0, 0, lat);
    chk("restart_err", int'(err_a), 0);
    chk("restart_pass", int'(pass_a), 1);
    mode_a = 0;
    start_a = 1;
    cycle();
    start_a = 0;
    for (int i = 0; i < 40 && stim_a != 4'd5; i++) cycle();
    chk("mid_stim5", int'(stim_a), 5);
    rst_n = 0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk_zero("post_rst");
    start_b = 1;
    cycle();
    start_b = 0;
    chk("b_busy0", int'(busy_b), 1);
    chk("b_stim0", int'(stim_b), 0);
    cycle();
    chk("b_stim1", int'(stim_b), 1);
    chk("b_busy1", int'(busy_b), 1);
    cycle();
    chk("b_done", int'(done_b), 1);
    chk("b_busy2", int'(busy_b), 0);
    chk("b_err", int'(err_b), 0);
    chk("b_pass", int'(pass_b), 1);
    chk("b_stim_end", int'(stim_b), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Synthesizable, self-checking exhaustive stimulus generator and checker for N-input reduction gates.
- Replaces hand-written per-gate truth-table benches.
- Drives every input combination 0..2^N-1 in ascending order, holding each vector for HOLD clocks, and samples the DUT output on the last hold cycle.
- Compares the sample against the golden function selected by `mode`, and reports the error count, the first failing vector and pass/fail.

Parameters:
- N, 4, number of gate inputs; legal range 1..16.
- HOLD, 100, clocks each vector is held; must be ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a sweep; sampled only in IDLE or DONE
- mode  in  2  golden function: 0=NAND, 1=NOR, 2=XOR, 3=XNOR; latched on accepted start
- dut_y  in  1  DUT output under test
- stim  out  N  vector driven to DUT inputs; bit N-1 = first input (a)
- busy  out  1  sweep in progress
- done  out  1  sweep complete; held until next accepted start
- pass  out  1  done && err_count==0
- err_count  out  N+1  mismatch count
- first_fail_valid  out  1  at least one mismatch recorded
- first_fail_vec  out  N  stim value of first mismatch

Behaviour:
- States: IDLE, SWEEP, DONE. All outputs are registered.
- Reset (rst_n low, asynchronous, any state including mid-sweep):
  - state=IDLE; stim=0, busy=0, done=0, err_count=0, first_fail_valid=0, first_fail_vec=0, hold_cnt=0, latched mode=0.
  - pass=0 (it is derived only from registered done/err_count).
  - No partial result survives reset.
- Accepting start (IDLE or DONE, start=1 at edge E0):
  - state=SWEEP, busy=1, done=0, stim=0, hold_cnt=0.
  - err_count, first_fail_valid and first_fail_vec are cleared; mode is latched.
- SWEEP, each edge:
  - If hold_cnt < HOLD-1: hold_cnt++; stim unchanged.
  - If hold_cnt == HOLD-1 (sample edge): compare dut_y with exp(stim).
    - exp: NAND = ~&stim, NOR = ~|stim, XOR = ^stim, XNOR = ~^stim.
    - On mismatch: err_count++. If first_fail_valid==0, also set first_fail_vec=stim and first_fail_valid=1.
    - Then, if stim == all-ones: state=DONE, busy=0, done=1, stim=0. Otherwise stim++ and hold_cnt=0.
- Latency: done rises at edge E0 + 2^N·HOLD. Each vector is visible on stim for exactly HOLD cycles.
- err_count width N+1 holds the maximum 2^N, so it never wraps and needs no saturation.
- start is ignored while in SWEEP. The mode input is ignored except on an accepted start.
- start held high in DONE restarts the sweep on the next edge. Clearing and restart happen on the same edge.
- HOLD=1: every edge is a sample edge. hold_cnt width is max(1, clog2(HOLD)).
- The DUT must settle within HOLD-1 cycles of a stim change. The checker samples combinationally-settled dut_y at the sample edge.
- dut_y X/Z is treated as a mismatch by the bench model only; the RTL compares 2-state.

Test Plan:
- N=4, HOLD=2, mode=0, correct NAND DUT, pulse start → stim steps 0..15, each for 2 cycles; done=1 at 32 cycles after start; err_count=0, pass=1, first_fail_valid=0, stim=0.
- Same setup, DUT forced y=1 only at stim=4'hF → err_count=1, first_fail_vec=4'hF, first_fail_valid=1, pass=0.
- Correct NAND DUT but mode=2 (XOR) → err_count=7 (even-parity vectors except 4'hF), first_fail_vec=4'h0, pass=0.
- Reset mid-sweep: rst_n low while stim=5 → all outputs 0 immediately, without waiting for a clock. After release, stays IDLE with stim=0 until start.
- Start pulsed while busy has no effect; sweep ends at the original 32-cycle mark. In DONE, start with mode=0 clears err_count from 7 to 0 and a fresh sweep passes.
- N=1, HOLD=1, mode=3 (XNOR) against an inverter DUT → vectors 0,1 on consecutive cycles; done after 2 cycles; err_count=0, pass=1.
